apb_slave_bank: RTL and testbench

Parametrised APB completer with an internal register bank. It is the next generation of the single-word APB slave interface, adding configurable data width, bank depth and wait states, plus error response (`slverr_o`) and optional byte strobes. It sits on the APB peripheral bus behind the requester/bridge and replaces the fixed slave-interface-plus-memory pair.

---
 rtl/apb_slv_pkg.sv | 18 +
 rtl/apb_slv_regfile.sv | 32 +++
 rtl/apb_slave_bank.sv | 126 ++++++++++++
 tb/tb_apb_slave_bank.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/apb_slv_pkg.sv
// Shared types and helpers for the APB completer with register bank.
// The byte-strobe option is controlled by APB_SLV_STRB_EN (see apb_slave_bank).
package apb_slv_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int APB_SLV_MAX_WAIT = 15;

  // Number of byte-offset bits inside one data word.
  function automatic int lsb_of(input int data_w);
    return $clog2(data_w / 8);
  endfunction

endpackage

// File: rtl/apb_slv_regfile.sv
// DEPTH x DATA_W register bank: synchronous clear, byte-enable write port,
// asynchronous read port.
module apb_slv_regfile #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 64,
  parameter int IDX_W  = 6
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                we,
  input  logic [IDX_W-1:0]    waddr,
  input  logic [DATA_W/8-1:0] be,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [IDX_W-1:0]    raddr,
  output logic [DATA_W-1:0]   rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (we) begin
      for (int b = 0; b < DATA_W / 8; b++) begin
        if (be[b]) mem[waddr][b*8 +: 8] <= wdata[b*8 +: 8];
      end
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/apb_slave_bank.sv
// APB completer with an internal register bank, programmable wait states and
// PSLVERR on out-of-range or misaligned access. Define APB_SLV_STRB_EN for PSTRB.
module apb_slave_bank
  import apb_slv_pkg::*;
#(
  parameter int ADDR_W      = 10,
  parameter int DATA_W      = 32,
  parameter int DEPTH       = 64,
  parameter int WAIT_CYCLES = 0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                select,
  input  logic                enable,
  input  logic [ADDR_W-1:0]   ADDR,
  input  logic                WRITE,
  input  logic [DATA_W-1:0]   WDATA,
`ifdef APB_SLV_STRB_EN
  input  logic [DATA_W/8-1:0] STRB,
`endif
  output logic [DATA_W-1:0]   RDATA,
  output logic                ready_o,
  output logic                slverr_o
);

  localparam int LSB   = lsb_of(DATA_W);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(APB_SLV_MAX_WAIT + 1);

  state_t             state, state_next;
  logic [CNT_W-1:0]   cnt, cnt_next;
  logic [ADDR_W:0]    word_ext;
  logic               misaligned, err, enter_resp, we;
  logic [DATA_W/8-1:0] be;
  logic [DATA_W-1:0]  rd_word, rdata_q;
  logic               ready_q, slverr_q;

  // Extra top bit keeps the range compare exact when DEPTH == 2**(ADDR_W-LSB).
  assign word_ext = {1'b0, ADDR} >> LSB;

  if (LSB > 0) begin : g_align
    assign misaligned = |ADDR[LSB-1:0];
  end else begin : g_no_align
    assign misaligned = 1'b0;
  end

  assign err = misaligned | (word_ext >= (ADDR_W + 1)'(DEPTH));

`ifdef APB_SLV_STRB_EN
  assign be = STRB;
`else
  assign be = '1;
`endif

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    unique case (state)
      IDLE: begin
        if (select && enable) begin
          if (WAIT_CYCLES == 0) begin
            state_next = RESP;
          end else begin
            state_next = WAIT;
            cnt_next   = CNT_W'(WAIT_CYCLES);
          end
        end
      end
      WAIT: begin
        if (!(select && enable)) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt - 1'b1;
          if (cnt == CNT_W'(1)) state_next = RESP;
        end
      end
      RESP: state_next = IDLE;
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  assign enter_resp = (state_next == RESP);

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      ready_q  <= 1'b0;
      slverr_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      state    <= state_next;
      cnt      <= cnt_next;
      ready_q  <= enter_resp;
      slverr_q <= enter_resp & err;
      rdata_q  <= (enter_resp && !WRITE && !err) ? rd_word : '0;
    end
  end

  // Bus is still held during RESP, so the write commits at the close of RESP.
  assign we = (state == RESP) && WRITE && !slverr_q;

  apb_slv_regfile #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W)
  ) u_regfile (
    .clk   (clk),
    .reset (reset),
    .we    (we),
    .waddr (word_ext[IDX_W-1:0]),
    .be    (be),
    .wdata (WDATA),
    .raddr (word_ext[IDX_W-1:0]),
    .rdata (rd_word)
  );

  assign RDATA    = rdata_q;
  assign ready_o  = ready_q;
  assign slverr_o = slverr_q;

endmodule

// File: tb/tb_apb_slave_bank.sv
// Bench for apb_slave_bank: one instance with no wait states, one with three.
module tb_apb_slave_bank;

  logic        clk = 1'b0;
  logic        rst0, rst1, sel0, sel1, enable, wr;
  logic [9:0]  addr;
  logic [31:0] wdata;
`ifdef APB_SLV_STRB_EN
  logic [3:0]  strb;
`endif
  logic [31:0] rdata0, rdata1;
  logic        rdy0, rdy1, err0, err1;

  int total = 0;
  int bad   = 0;
  logic [32:0] exp_q[$];

  always #5 clk = ~clk;

  apb_slave_bank #(.ADDR_W(10), .DATA_W(32), .DEPTH(64), .WAIT_CYCLES(0)) u_dut0 (
    .clk(clk), .reset(rst0), .select(sel0), .enable(enable), .ADDR(addr),
    .WRITE(wr), .WDATA(wdata),
`ifdef APB_SLV_STRB_EN
    .STRB(strb),
`endif
    .RDATA(rdata0), .ready_o(rdy0), .slverr_o(err0)
  );

  apb_slave_bank #(.ADDR_W(10), .DATA_W(32), .DEPTH(64), .WAIT_CYCLES(3)) u_dut1 (
    .clk(clk), .reset(rst1), .select(sel1), .enable(enable), .ADDR(addr),
    .WRITE(wr), .WDATA(wdata),
`ifdef APB_SLV_STRB_EN
    .STRB(strb),
`endif
    .RDATA(rdata1), .ready_o(rdy1), .slverr_o(err1)
  );

  function automatic logic rdy_of(input int d);
    return (d == 0) ? rdy0 : rdy1;
  endfunction

  function automatic logic err_of(input int d);
    return (d == 0) ? err0 : err1;
  endfunction

  function automatic logic [31:0] rdata_of(input int d);
    return (d == 0) ? rdata0 : rdata1;
  endfunction

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // One complete transfer: setup phase, access phase until ready_o (bounded).
  task automatic xfer(input int d, input bit w, input logic [9:0] a, input logic [31:0] wd,
                      input logic [3:0] st, input logic [32:0] exp, input int lat);
    logic [32:0] e;
    int c;
    bit seen;
    exp_q.push_back(exp);
    @(posedge clk); #1;
    if (d == 0) sel0 = 1'b1; else sel1 = 1'b1;
    enable = 1'b0;
    wr     = w;
    addr   = a;
    wdata  = wd;
`ifdef APB_SLV_STRB_EN
    strb   = st;
`endif
    @(posedge clk); #1;
    enable = 1'b1;
    c    = 1;
    seen = 1'b0;
    while (!seen && c <= 24) begin
      if (rdy_of(d)) seen = 1'b1;
      else begin
        @(posedge clk); #1;
        c++;
      end
    end
    check($sformatf("latency d%0d a%0h", d, a), c, lat);
    e = exp_q.pop_front();
    if (seen) begin
      check($sformatf("rdata d%0d a%0h", d, a), rdata_of(d), e[31:0]);
      check($sformatf("slverr d%0d a%0h", d, a), err_of(d), e[32]);
    end
    @(posedge clk); #1;
    sel0   = 1'b0;
    sel1   = 1'b0;
    enable = 1'b0;
    check($sformatf("ready one cycle d%0d", d), rdy_of(d), 1'b0);
  endtask

  typedef struct {
    bit          w;
    logic [9:0]  a;
    logic [31:0] wd;
    logic [31:0] exp_rdata;
    bit          exp_err;
  } vec_t;

  vec_t vecs[12];
  logic [31:0] model[8];
  logic [31:0] strb_exp;

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    vecs[0]  = '{1'b1, 10'h004, 32'hDEADBEEF, 32'h0,        1'b0};
    vecs[1]  = '{1'b0, 10'h004, 32'h0,        32'hDEADBEEF, 1'b0};
    vecs[2]  = '{1'b1, 10'h100, 32'h11111111, 32'h0,        1'b1};
    vecs[3]  = '{1'b1, 10'h006, 32'h22222222, 32'h0,        1'b1};
    vecs[4]  = '{1'b0, 10'h004, 32'h0,        32'hDEADBEEF, 1'b0};
    vecs[5]  = '{1'b0, 10'h100, 32'h0,        32'h0,        1'b1};
    vecs[6]  = '{1'b1, 10'h0FC, 32'h5A5AA5A5, 32'h0,        1'b0};
    vecs[7]  = '{1'b0, 10'h0FC, 32'h0,        32'h5A5AA5A5, 1'b0};
    vecs[8]  = '{1'b0, 10'h000, 32'h0,        32'h0,        1'b0};
    vecs[9]  = '{1'b0, 10'h3FF, 32'h0,        32'h0,        1'b1};
    vecs[10] = '{1'b1, 10'h008, 32'h11223344, 32'h0,        1'b0};
    vecs[11] = '{1'b0, 10'h008, 32'h0,        32'h11223344, 1'b0};

    rst0 = 1'b1; rst1 = 1'b1; sel0 = 1'b0; sel1 = 1'b0; enable = 1'b0;
    wr = 1'b0; addr = '0; wdata = '0;
`ifdef APB_SLV_STRB_EN
    strb = 4'hF;
`endif
    repeat (3) @(posedge clk);
    #1;
    check("reset ready0", rdy0, 1'b0);
    check("reset slverr0", err0, 1'b0);
    check("reset rdata0", rdata0, 32'h0);
    check("reset ready1", rdy1, 1'b0);
    check("reset slverr1", err1, 1'b0);
    check("reset rdata1", rdata1, 32'h0);
    rst0 = 1'b0; rst1 = 1'b0;

    // Setup phase alone must not start a transfer.
    @(posedge clk); #1;
    sel0 = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      check("setup only ready0", rdy0, 1'b0);
    end
    sel0 = 1'b0;

    for (int i = 0; i < 12; i++)
      xfer(0, vecs[i].w, vecs[i].a, vecs[i].wd, 4'hF, {vecs[i].exp_err, vecs[i].exp_rdata}, 2);

`ifdef APB_SLV_STRB_EN
    strb_exp = 32'h11BB33DD;
`else
    strb_exp = 32'hAABBCCDD;
`endif
    xfer(0, 1'b1, 10'h008, 32'hAABBCCDD, 4'b0101, {1'b0, 32'h0}, 2);
    xfer(0, 1'b0, 10'h008, 32'h0, 4'hF, {1'b0, strb_exp}, 2);
`ifdef APB_SLV_STRB_EN
    xfer(0, 1'b1, 10'h008, 32'hFFFFFFFF, 4'b0000, {1'b0, 32'h0}, 2);
    xfer(0, 1'b0, 10'h008, 32'h0, 4'hF, {1'b0, strb_exp}, 2);
`endif

    for (int i = 0; i < 8; i++) begin
      model[i] = $urandom;
      xfer(0, 1'b1, 10'((16 + i) * 4), model[i], 4'hF, {1'b0, 32'h0}, 2);
    end
    for (int i = 7; i >= 0; i--)
      xfer(0, 1'b0, 10'((16 + i) * 4), 32'h0, 4'hF, {1'b0, model[i]}, 2);

    // Three wait states.
    xfer(1, 1'b0, 10'h000, 32'h0, 4'hF, {1'b0, 32'h0}, 5);
    xfer(1, 1'b1, 10'h00C, 32'h0BADF00D, 4'hF, {1'b0, 32'h0}, 5);
    xfer(1, 1'b1, 10'h100, 32'h0, 4'hF, {1'b1, 32'h0}, 5);

    // Abort: drop enable in the second wait cycle of a write.
    @(posedge clk); #1;
    sel1 = 1'b1; enable = 1'b0; wr = 1'b1; addr = 10'h00C; wdata = 32'hFFFFFFFF;
`ifdef APB_SLV_STRB_EN
    strb = 4'hF;
`endif
    @(posedge clk); #1;
    enable = 1'b1;
    @(posedge clk); #1;
    check("abort first wait ready", rdy1, 1'b0);
    @(posedge clk); #1;
    enable = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      check("abort ready", rdy1, 1'b0);
    end
    sel1 = 1'b0;
    xfer(1, 1'b0, 10'h00C, 32'h0, 4'hF, {1'b0, 32'h0BADF00D}, 5);

    // Reset in the middle of a wait-stated write.
    xfer(1, 1'b1, 10'h010, 32'h12345678, 4'hF, {1'b0, 32'h0}, 5);
    @(posedge clk); #1;
    sel1 = 1'b1; enable = 1'b0; wr = 1'b1; addr = 10'h010; wdata = 32'hFFFFFFFF;
    @(posedge clk); #1;
    enable = 1'b1;
    @(posedge clk); #1;
    rst1 = 1'b1;
    @(posedge clk); #1;
    check("reset mid-wait ready", rdy1, 1'b0);
    check("reset mid-wait slverr", err1, 1'b0);
    check("reset mid-wait rdata", rdata1, 32'h0);
    rst1 = 1'b0; sel1 = 1'b0; enable = 1'b0;
    @(posedge clk); #1;
    check("after reset ready", rdy1, 1'b0);
    for (int i = 0; i < 64; i++)
      xfer(1, 1'b0, 10'(i * 4), 32'h0, 4'hF, {1'b0, 32'h0}, 5);

    // Reset of one instance must not disturb the other.
    xfer(0, 1'b0, 10'h004, 32'h0, 4'hF, {1'b0, 32'hDEADBEEF}, 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
